// File: rtl/ahb3lite_imem_responder.sv
// Read-only AHB3-Lite instruction-memory responder with a loadable program array and fixed wait states.
// Optional two-cycle ERROR response for misses and writes when IMEM_ERR_RESP_EN is defined.
module ahb3lite_imem_responder #(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE        = 32'h200,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_WORD    = 32'h13
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [3:0]               HPROT,
  input  logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data,
  output logic [31:0]              fetch_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_ERR1 = 2'b10;
  localparam logic [1:0] S_ERR2 = 2'b11;

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] mem_q [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        wr_q, wr_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [31:0] fetch_q, fetch_d;

  logic [31:0]   off;
  logic          hit;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rd_word;
  logic          can_accept;
  logic          accept;
  logic          err_cond;

  // Address decode: the byte offset from BASE selects a word, low two bits ignored.
  assign off      = HADDR - BASE;
  assign hit      = (HADDR >= BASE) && (off[31:AW+2] == '0);
  assign acc_idx  = off[AW+1:2];
  assign rd_word  = hit ? mem_q[acc_idx] : NOP_WORD;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign accept     = HSEL && HTRANS[1] && HREADY && can_accept;

`ifdef IMEM_ERR_RESP_EN
  assign err_cond = !hit || HWRITE;
  assign HRESP    = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
  assign err_cond = 1'b0;
  assign HRESP    = 1'b0;
`endif

  assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign HRDATA    = hrdata_q;
  assign fetch_cnt = fetch_q;

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HBURST, HPROT, HTRANS[0], off[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    wr_d     = wr_q;
    hrdata_d = hrdata_q;
    fetch_d  = fetch_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          if (err_cond) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            // Array word is captured now so a same-cycle load cannot alter this read.
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
            buf_d   = rd_word;
            wr_d    = HWRITE;
          end else if (!HWRITE) begin
            hrdata_d = rd_word;
            fetch_d  = fetch_q + 32'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (!wr_q) begin
            hrdata_d = buf_q;
            fetch_d  = fetch_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      buf_q    <= NOP_WORD;
      wr_q     <= 1'b0;
      hrdata_q <= NOP_WORD;
      fetch_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      wr_q     <= wr_d;
      hrdata_q <= hrdata_d;
      fetch_q  <= fetch_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else if (ld_we) begin
      mem_q[ld_idx] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ahb3lite_imem_responder.sv
// Bench for ahb3lite_imem_responder: a zero-wait instance driven from a vector table with a
// scoreboard, and a three-wait-state instance exercised by hand-written sequences.
`timescale 1ns/1ps
module tb_ahb3lite_imem_responder;

  localparam int AW = 8;

`ifdef IMEM_ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sel0, selw;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize, hburst;
  logic [3:0]    hprot;
  logic          ld_we;
  logic [AW-1:0] ld_idx;
  logic [31:0]   ld_data;
  logic [31:0]   rdata0, rdataw, fcnt0, fcntw;
  logic          rdy0, rdyw, resp0, respw;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb3lite_imem_responder dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data), .fetch_cnt(fcnt0)
  );

  ahb3lite_imem_responder #(.WAIT_STATES(3)) dutw (
    .HCLK(clk), .HRESET(rst), .HSEL(selw), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HREADY(rdyw),
    .HRDATA(rdataw), .HREADYOUT(rdyw), .HRESP(respw),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data), .fetch_cnt(fcntw)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic        err;
    logic [31:0] data;
    logic        counts;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    int          tag;
  } exp_t;

  localparam int NV = 15;
  vec_t vt [NV];
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic s0, input logic sw, input logic [1:0] tr,
                     input logic [31:0] a, input logic w);
    sel0 = s0; selw = sw; htrans = tr; haddr = a; hwrite = w;
  endtask

  task automatic load(input logic [AW-1:0] i, input logic [31:0] d);
    ld_we = 1'b1; ld_idx = i; ld_data = d;
    next();
    ld_we = 1'b0;
  endtask

  task automatic pop_chk();
    exp_t e;
    e = sb.pop_front();
    chk($sformatf("vec%0d_hreadyout", e.tag), 32'(rdy0), 32'(e.rdy));
    chk($sformatf("vec%0d_hresp", e.tag), 32'(resp0), 32'(e.resp));
    chk($sformatf("vec%0d_hrdata", e.tag), rdata0, e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   exp_cnt;
    exp_t e;

    // sel, trans, addr, write, err, expected HRDATA, counted
    vt[0]  = '{1'b1, 2'b10, 32'h200, 1'b0, 1'b0, 32'h0ff57513, 1'b1};
    vt[1]  = '{1'b1, 2'b11, 32'h204, 1'b0, 1'b0, 32'h00100093, 1'b1};
    vt[2]  = '{1'b1, 2'b11, 32'h208, 1'b0, 1'b0, 32'h00200113, 1'b1};
    vt[3]  = '{1'b1, 2'b00, 32'h20C, 1'b0, 1'b0, 32'h00200113, 1'b0};
    vt[4]  = '{1'b1, 2'b01, 32'h20C, 1'b0, 1'b0, 32'h00200113, 1'b0};
    vt[5]  = '{1'b1, 2'b10, 32'h20E, 1'b0, 1'b0, 32'h00300193, 1'b1};
    vt[6]  = '{1'b1, 2'b10, 32'h210, 1'b0, 1'b0, 32'h00000013, 1'b1};
    vt[7]  = '{1'b1, 2'b10, 32'h5FC, 1'b0, 1'b0, 32'hdeadbe13, 1'b1};
    vt[8]  = '{1'b1, 2'b10, 32'h1FC, 1'b0, ERR, ERR ? 32'hdeadbe13 : 32'h13, !ERR};
    vt[9]  = '{1'b1, 2'b10, 32'h600, 1'b0, ERR, ERR ? 32'hdeadbe13 : 32'h13, !ERR};
    vt[10] = '{1'b1, 2'b10, 32'h200, 1'b1, ERR, ERR ? 32'hdeadbe13 : 32'h13, 1'b0};
    vt[11] = '{1'b0, 2'b10, 32'h204, 1'b0, 1'b0, ERR ? 32'hdeadbe13 : 32'h13, 1'b0};
    vt[12] = '{1'b1, 2'b10, 32'h204, 1'b0, 1'b0, 32'h00100093, 1'b1};
    vt[13] = '{1'b1, 2'b10, 32'h000, 1'b0, ERR, ERR ? 32'h00100093 : 32'h13, !ERR};
    vt[14] = '{1'b1, 2'b10, 32'h200, 1'b0, 1'b0, 32'h0ff57513, 1'b1};

    rst = 1'b1;
    bus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011;
    ld_we = 1'b0; ld_idx = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset defaults on both instances
    @(negedge clk);
    chk("rst_hreadyout0", 32'(rdy0), 32'd1);
    chk("rst_hresp0", 32'(resp0), 32'd0);
    chk("rst_hrdata0", rdata0, 32'h13);
    chk("rst_fetch0", fcnt0, 32'd0);
    chk("rst_hreadyoutw", 32'(rdyw), 32'd1);
    chk("rst_hrdataw", rdataw, 32'h13);

    next();
    load(8'd0, 32'h0ff57513);
    load(8'd1, 32'h00100093);
    load(8'd2, 32'h00200113);
    load(8'd3, 32'h00300193);
    load(8'd5, 32'hAAAA0013);
    load(8'd255, 32'hdeadbe13);

    // Table: address phases on the zero-wait instance, held while HREADYOUT is low
    exp_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      bus(vt[i].sel, 1'b0, vt[i].trans, vt[i].addr, vt[i].wr);
      w = 0;
      forever begin
        @(negedge clk);
        if (sb.size() > 0) pop_chk();
        if (rdy0) break;
        w++;
        if (w > 8) begin
          n_chk++; n_fail++;
          $display("FAIL vec%0d_hready_timeout: got hreadyout 0, expected 1", i);
          break;
        end
      end
      if (vt[i].err) begin
        e = '{1'b0, 1'b1, vt[i].data, i}; sb.push_back(e);
        e = '{1'b1, 1'b1, vt[i].data, i}; sb.push_back(e);
      end else begin
        e = '{1'b1, 1'b0, vt[i].data, i}; sb.push_back(e);
      end
      if (vt[i].counts) exp_cnt++;
      next();
    end
    bus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      pop_chk();
    end
    chk("table_fetch_cnt", fcnt0, 32'(exp_cnt));

    // Load and read of the same index in one cycle: the read sees the old word
    next();
    ld_we = 1'b1; ld_idx = 8'd5; ld_data = 32'h55550013;
    bus(1'b1, 1'b0, 2'b10, 32'h214, 1'b0);
    next();
    ld_we = 1'b0;
    @(negedge clk);
    chk("coll_old", rdata0, 32'hAAAA0013);
    next();
    bus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    @(negedge clk);
    chk("coll_new", rdata0, 32'h55550013);
    chk("coll_fetch_cnt", fcnt0, 32'(exp_cnt + 2));

    // Three wait states: HREADYOUT low for cycles 1..3, data in cycle 4
    next();
    bus(1'b0, 1'b1, 2'b10, 32'h200, 1'b0);
    next();
    bus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("ws_c%0d_hreadyout", c), 32'(rdyw), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("ws_c%0d_hrdata", c), rdataw, (c == 4) ? 32'h0ff57513 : 32'h13);
    end
    chk("ws_fetch_cnt", fcntw, 32'd1);
    @(negedge clk);
    chk("ws_hold_hrdata", rdataw, 32'h0ff57513);

    // Miss on the wait-state instance: no wait states when it errors
    next();
    bus(1'b0, 1'b1, 2'b10, 32'h600, 1'b0);
    next();
    bus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("wsmiss_c%0d_hreadyout", c), 32'(rdyw),
          ERR ? 32'(c >= 2) : 32'(c == 4));
      chk($sformatf("wsmiss_c%0d_hresp", c), 32'(respw), ERR ? 32'(c <= 2) : 32'd0);
      chk($sformatf("wsmiss_c%0d_hrdata", c), rdataw,
          (!ERR && c == 4) ? 32'h13 : 32'h0ff57513);
    end
    chk("wsmiss_fetch_cnt", fcntw, ERR ? 32'd1 : 32'd2);

    // Reset in the second wait cycle: no late data phase afterwards
    next();
    bus(1'b0, 1'b1, 2'b10, 32'h204, 1'b0);
    next();
    bus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    @(negedge clk);
    chk("rstmid_wait1_hreadyout", 32'(rdyw), 32'd0);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_k%0d_hreadyout", k), 32'(rdyw), 32'd1);
      chk($sformatf("rstmid_k%0d_hresp", k), 32'(respw), 32'd0);
      chk($sformatf("rstmid_k%0d_fetch", k), fcntw, 32'd0);
      chk($sformatf("rstmid_k%0d_hrdata", k), rdataw, 32'h13);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
